// File: rtl/reg_alu_seq.sv
// Instruction sequencer for a register-file/ALU block.
// It accepts one instruction at a time, drives the reg_alu control signals and returns READ results.
module reg_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [12:0] instr,
    input  logic [15:0] imm,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        carry_flag,
    output logic [7:0]  retired,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    input  logic [15:0] d_out_a,
    input  logic        cout
);

    localparam logic [1:0] CLS_LOADI = 2'b00;
    localparam logic [1:0] CLS_ALU   = 2'b01;
    localparam logic [1:0] CLS_READ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t      state;
    logic [12:0] instr_q;
    logic [15:0] imm_q;
    logic [1:0]  cls_q;

    assign cls_q = instr_q[12:11];

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds its payload until then. instr_ready depends only on state, and
    // res_valid/res_data stay put until res_ready is seen.
    assign instr_ready = (state == IDLE);

    // The reg_alu controls come straight from the latched instruction in every state.
    assign rd_addr_a = instr_q[5:3];
    assign rd_addr_b = instr_q[2:0];
    assign wr_addr   = instr_q[8:6];
    assign op        = instr_q[10:9];
    assign d_in      = imm_q;
    assign sel       = (cls_q == CLS_ALU);

    // The write enable is gated by reset, so an aborted EXEC never reaches the register file.
    assign wr = reset && (state == EXEC) && ((cls_q == CLS_LOADI) || (cls_q == CLS_ALU));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            instr_q    <= 13'd0;
            imm_q      <= 16'd0;
            res_valid  <= 1'b0;
            res_data   <= 16'd0;
            carry_flag <= 1'b0;
            retired    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        imm_q   <= imm;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cls_q == CLS_ALU) begin
                        carry_flag <= cout;
                    end
                    if (cls_q == CLS_READ) begin
                        res_data  <= d_out_a;
                        res_valid <= 1'b1;
                        state     <= WAIT_RES;
                    end else begin
                        retired <= retired + 8'd1;
                        state   <= IDLE;
                    end
                end
                WAIT_RES: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        retired   <= retired + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_seq.sv
// Directed bench for reg_alu_seq with a small behavioural reg_alu (8 x 16-bit registers and an ALU).
// It works through the load, ALU, read, stall, reset-abort, NOP-wrap and self-overwrite scenarios.
module tb_reg_alu_seq;

    localparam logic [1:0] LOADI = 2'b00;
    localparam logic [1:0] ALU   = 2'b01;
    localparam logic [1:0] READ  = 2'b10;
    localparam logic [1:0] NOP   = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [12:0] instr;
    logic [15:0] imm;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        carry_flag;
    logic [7:0]  retired;
    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic [15:0] d_out_a;
    logic        cout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_ret = 8'd0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reg_alu environment model ----------------
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] d_out_b;
    logic [16:0] alu_full;

    assign d_out_a = rf[rd_addr_a];
    assign d_out_b = rf[rd_addr_b];

    always_comb begin
        alu_full = 17'd0;
        case (op)
            2'b00: alu_full = {1'b0, d_out_a} + {1'b0, d_out_b};
            2'b01: alu_full = {1'b0, d_out_a} - {1'b0, d_out_b};
            2'b10: alu_full = {1'b0, d_out_a & d_out_b};
            default: alu_full = {1'b0, d_out_a | d_out_b};
        endcase
    end
    assign cout = alu_full[16];

    always @(posedge clk) begin
        if (wr) rf[wr_addr] <= sel ? alu_full[15:0] : d_in;
    end

    reg_alu_seq dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .carry_flag  (carry_flag),
        .retired     (retired),
        .sel         (sel),
        .wr          (wr),
        .op          (op),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .wr_addr     (wr_addr),
        .d_in        (d_in),
        .d_out_a     (d_out_a),
        .cout        (cout)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one instruction while in IDLE; returns #1 after the accepting edge, in EXEC.
    // The payload is scrambled after the accept so that a design which keeps sampling it shows up.
    task automatic send(input logic [1:0] cls, input logic [1:0] aop, input logic [2:0] dst,
                        input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] immv);
        instr       = {cls, aop, dst, sa, sb};
        imm         = immv;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr       = 13'($urandom_range(0, 8191));
        imm         = 16'($urandom_range(0, 65535));
    endtask

    task automatic run_op(input logic [1:0] cls, input logic [1:0] aop, input logic [2:0] dst,
                          input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] immv);
        send(cls, aop, dst, sa, sb, immv);
        step();
        exp_ret = exp_ret + 8'd1;
    endtask

    task automatic read_reg(input string tag, input logic [2:0] src, input logic [15:0] exp);
        send(READ, 2'b00, 3'd0, src, 3'd0, 16'h0000);
        chk({tag, "_valid_early"}, 16'(res_valid), 16'd0);
        step();
        chk({tag, "_valid"}, 16'(res_valid), 16'd1);
        chk({tag, "_data"}, res_data, exp);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        exp_ret = exp_ret + 8'd1;
        chk({tag, "_valid_clr"}, 16'(res_valid), 16'd0);
        chk({tag, "_ready"}, 16'(instr_ready), 16'd1);
    endtask

    // Safety net: the sequence below uses fixed cycle counts, so this should never fire.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b0;
        instr_valid = 1'b1;
        instr       = 13'h1FFF;
        imm         = 16'hFFFF;
        res_ready   = 1'b1;
        step();
        step();

        // Reset state (a valid instruction is offered during reset and must be ignored)
        chk("rst_instr_ready", 16'(instr_ready), 16'd1);
        chk("rst_wr",          16'(wr),          16'd0);
        chk("rst_sel",         16'(sel),         16'd0);
        chk("rst_op",          16'(op),          16'd0);
        chk("rst_rd_addr_a",   16'(rd_addr_a),   16'd0);
        chk("rst_rd_addr_b",   16'(rd_addr_b),   16'd0);
        chk("rst_wr_addr",     16'(wr_addr),     16'd0);
        chk("rst_d_in",        d_in,             16'h0000);
        chk("rst_res_valid",   16'(res_valid),   16'd0);
        chk("rst_res_data",    res_data,         16'h0000);
        chk("rst_carry",       16'(carry_flag),  16'd0);
        chk("rst_retired",     16'(retired),     16'd0);
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        reset       = 1'b1;
        step();

        // S1: LOADI r3=1234, READ r3
        send(LOADI, 2'b00, 3'd3, 3'd0, 3'd0, 16'h1234);
        chk("s1_exec_wr",      16'(wr),          16'd1);
        chk("s1_exec_sel",     16'(sel),         16'd0);
        chk("s1_exec_wr_addr", 16'(wr_addr),     16'd3);
        chk("s1_exec_d_in",    d_in,             16'h1234);
        chk("s1_exec_ready",   16'(instr_ready), 16'd0);
        step();
        exp_ret = exp_ret + 8'd1;
        chk("s1_ready_back",   16'(instr_ready), 16'd1);
        chk("s1_retired1",     16'(retired),     16'(exp_ret));
        read_reg("s1_read", 3'd3, 16'h1234);
        chk("s1_retired2",     16'(retired),     16'd2);

        // S2: FFFF + 0001 -> 0000 with carry
        run_op(LOADI, 2'b00, 3'd1, 3'd0, 3'd0, 16'hFFFF);
        run_op(LOADI, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0001);
        send(ALU, 2'b00, 3'd4, 3'd1, 3'd2, 16'h0000);
        chk("s2_exec_wr",   16'(wr),        16'd1);
        chk("s2_exec_sel",  16'(sel),       16'd1);
        chk("s2_exec_op",   16'(op),        16'd0);
        chk("s2_exec_ra",   16'(rd_addr_a), 16'd1);
        chk("s2_exec_rb",   16'(rd_addr_b), 16'd2);
        step();
        exp_ret = exp_ret + 8'd1;
        chk("s2_carry",     16'(carry_flag), 16'd1);
        read_reg("s2_read", 3'd4, 16'h0000);
        chk("s2_carry_hold", 16'(carry_flag), 16'd1);
        chk("s2_retired",   16'(retired),   16'(exp_ret));

        // S3: READ r1 stalled for 5 cycles while a LOADI is offered
        send(READ, 2'b00, 3'd0, 3'd1, 3'd0, 16'h0000);
        step();
        instr       = {LOADI, 2'b00, 3'd7, 3'd0, 3'd0};
        imm         = 16'h7777;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("s3_valid_hold", 16'(res_valid),   16'd1);
            chk("s3_data_hold",  res_data,         16'hFFFF);
            chk("s3_not_ready",  16'(instr_ready), 16'd0);
            chk("s3_no_wr",      16'(wr),          16'd0);
            chk("s3_latched_ra", 16'(rd_addr_a),   16'd1);
            step();
        end
        res_ready   = 1'b1;
        instr_valid = 1'b0;
        step();
        res_ready = 1'b0;
        exp_ret = exp_ret + 8'd1;
        chk("s3_ready_1cyc", 16'(instr_ready), 16'd1);
        chk("s3_valid_clr",  16'(res_valid),   16'd0);
        chk("s3_retired",    16'(retired),     16'(exp_ret));
        read_reg("s3_r7_untouched", 3'd7, 16'h0000);

        // S4: reset during EXEC of LOADI r5=ABCD aborts it
        send(LOADI, 2'b00, 3'd5, 3'd0, 3'd0, 16'hABCD);
        chk("s4_wr_before", 16'(wr), 16'd1);
        reset = 1'b0;
        #1;
        chk("s4_wr_in_reset", 16'(wr), 16'd0);
        step();
        reset = 1'b1;
        exp_ret = 8'd0;
        chk("s4_retired",   16'(retired),     16'd0);
        chk("s4_carry",     16'(carry_flag),  16'd0);
        chk("s4_ready",     16'(instr_ready), 16'd1);
        chk("s4_res_data",  res_data,         16'h0000);
        read_reg("s4_read_r5", 3'd5, 16'h0000);
        chk("s4_retired_after", 16'(retired), 16'd1);

        // S6: r1 = r1 + r1 with r1 = 3
        run_op(LOADI, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0003);
        run_op(ALU,   2'b00, 3'd1, 3'd1, 3'd1, 16'h0000);
        chk("s6_carry", 16'(carry_flag), 16'd0);
        read_reg("s6_read_r1", 3'd1, 16'h0006);

        // Set carry (FFFF+FFFF) so that the NOP run can show it is left alone
        run_op(LOADI, 2'b00, 3'd2, 3'd0, 3'd0, 16'hFFFF);
        run_op(ALU,   2'b00, 3'd0, 3'd2, 3'd2, 16'h0000);
        chk("pre_s5_carry", 16'(carry_flag), 16'd1);

        // S5: 256 back-to-back NOPs; retired passes through 255 -> 0 on the way
        instr       = {NOP, 2'b00, 3'd0, 3'd2, 3'd2};
        imm         = 16'h5A5A;
        instr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            chk("s5_ready_idle", 16'(instr_ready), 16'd1);
            step();
            chk("s5_ready_exec", 16'(instr_ready), 16'd0);
            chk("s5_no_wr",      16'(wr),          16'd0);
            step();
            exp_ret = exp_ret + 8'd1;
            chk("s5_retired",    16'(retired),     16'(exp_ret));
        end
        instr_valid = 1'b0;
        chk("s5_carry_kept", 16'(carry_flag), 16'd1);
        read_reg("s5_r0_kept", 3'd0, 16'hFFFE);
        chk("s5_final_retired", 16'(retired), 16'(exp_ret));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
